uart_tx_port: RTL and testbench
===============================

UART_TX_PORT -- requirements
Module: uart_tx_port

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; legal range 2..1023.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 data_in  input  8  byte to transmit; driven from a CPU output-port register.
REQ-005 wr  input  1  load strobe, one cycle; samples data_in.
REQ-006 clr_ovr  input  1  clears sticky overrun flag.
REQ-007 tx  output  1  serial line; idle high.
REQ-008 busy  output  1  high while a frame is in progress.
REQ-009 status  output  8  {6'b0, ovr, busy}, for direct connection to a CPU input port.

Function
REQ-010 FSM states SHALL be exactly IDLE, START, DATA, STOP.
REQ-011 IDLE: tx=1, busy=0; on wr=1, latch data_in into shift register, clear bit counter, and enter START next edge.
REQ-012 START: tx=0 for exactly CLKS_PER_BIT cycles, then DATA.
REQ-013 DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles; after bit 7, STOP.
REQ-014 STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
REQ-015 busy SHALL be high in START, DATA, STOP: from the cycle after the accepting wr edge through the last STOP cycle.
REQ-016 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles, from the first tx=0 cycle to the first IDLE cycle.
REQ-017 tx SHALL be registered, with no combinational path from wr or data_in.
REQ-018 Baud counter SHALL count 0..CLKS_PER_BIT-1, reload to 0 on every state or bit change, and never run in IDLE.
REQ-019 wr while busy=1 SHALL be ignored: the frame and shift register are unchanged, and ovr is set to 1 on the next edge.
REQ-020 ovr is sticky; clr_ovr=1 clears it next edge; a simultaneous overrun wr and clr_ovr SHALL leave ovr=1 (set wins).
REQ-021 Back-to-back: wr in the first IDLE cycle after STOP SHALL be accepted without overrun, giving exactly one idle-high cycle between frames.
REQ-022 data_in changes after the accepting edge SHALL NOT affect the frame in progress.
REQ-023 Bit counter width SHALL be 3 bits; the baud counter width SHALL be $clog2(CLKS_PER_BIT).

Reset
REQ-024 reset=1 SHALL, at the next edge, force state=IDLE, tx=1, busy=0, ovr=0, baud counter=0, bit counter=0, shift register=0.
REQ-025 Reset mid-frame SHALL abort the frame immediately; no partial bits follow reset deassertion.
REQ-026 reset has priority over wr and clr_ovr in the same cycle.

Structure
REQ-027 A shared package SHALL hold the state encoding (2-bit enum IDLE=0, START=1, DATA=2, STOP=3) and the default CLKS_PER_BIT constant.
REQ-028 One sub-module, baud_tick, SHALL implement the parameterised baud counter with restart input and terminal-count output.
REQ-029 Shift register, bit counter, FSM and ovr flag SHALL reside in uart_tx_port.

Verification (CLKS_PER_BIT=4)
REQ-030 wr with data_in=0xA5 from IDLE -> tx = 0 | 1,0,1,0,0,1,0,1 | 1, each level held 4 cycles; busy high 40 cycles; ovr=0.
REQ-031 wr 0x3C, then wr 0xFF on cycle 10 of the frame -> the 0x3C frame completes unaltered; ovr=1; status=8'h03 during the frame and 8'h02 after it.
REQ-032 After REQ-031, clr_ovr=1 together with an overrun wr -> ovr stays 1; clr_ovr alone next cycle -> ovr=0.
REQ-033 wr 0x00, then wr 0xFF in the first IDLE cycle after STOP -> accepted, one idle-high cycle between frames, ovr=0.
REQ-034 reset=1 during DATA bit 3 -> next edge tx=1, busy=0, status=8'h00; line stays high until a new wr.
REQ-035 wr together with reset=1 -> no frame started; tx stays 1 for 50 cycles.

Source files
------------

// File: rtl/uart_tx_port_pkg.sv
// Shared definitions for the UART transmit port: state encoding and default bit timing.
package uart_tx_port_pkg;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 16;
  localparam int unsigned DATA_W               = 8;
  localparam int unsigned STATUS_W             = 8;
  localparam int unsigned BIT_CNT_W            = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

endpackage

// File: rtl/uart_tx_port_if.sv
// CPU-side port bundle of the UART transmitter: byte load, overrun clear and line/status outputs.
interface uart_tx_port_if;
  import uart_tx_port_pkg::*;

  logic [DATA_W-1:0]   data_in;
  logic                wr;
  logic                clr_ovr;
  logic                tx;
  logic                busy;
  logic [STATUS_W-1:0] status;

  modport master (
    output data_in, wr, clr_ovr,
    input  tx, busy, status
  );

  modport slave (
    input  data_in, wr, clr_ovr,
    output tx, busy, status
  );

endinterface

// File: rtl/uart_tx_port_baud_tick.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit period.
module baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tc_c
);

  localparam int unsigned          CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]     LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // Wrapping on terminal count reloads the counter at every bit or state boundary.
  always_ff @(posedge clk) begin
    if (reset || restart || tc_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc_c = (cnt == LAST);

endmodule

// File: rtl/uart_tx_port.sv
// UART transmitter with a CPU byte port: 8N1 framing, busy/overrun status, sticky overrun flag.
module uart_tx_port
  import uart_tx_port_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_port_if.slave  bus
);

  state_t                 state;
  logic [DATA_W-1:0]      shift_q;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic                   tx_q;
  logic                   busy_q;
  logic                   ovr_q;
  logic                   tick_c;
  logic                   restart_c;

  // Counter is held at zero while idle so every frame starts on a clean bit period.
  assign restart_c = (state == IDLE);

  baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (restart_c),
    .tc_c    (tick_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      shift_q <= '0;
      bit_cnt <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      // A load attempt during a frame is dropped but flagged; it outranks a clear.
      if (bus.wr && busy_q) begin
        ovr_q <= 1'b1;
      end else if (bus.clr_ovr) begin
        ovr_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (bus.wr) begin
            shift_q <= bus.data_in;
            bit_cnt <= '0;
            state   <= START;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (tick_c) begin
            state <= DATA;
            tx_q  <= shift_q[0];
          end
        end
        DATA: begin
          if (tick_c) begin
            if (bit_cnt == BIT_CNT_W'(7)) begin
              state <= STOP;
              tx_q  <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + BIT_CNT_W'(1);
              shift_q <= {1'b0, shift_q[DATA_W-1:1]};
              tx_q    <= shift_q[1];
            end
          end
        end
        STOP: begin
          if (tick_c) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx     = tx_q;
  assign bus.busy   = busy_q;
  assign bus.status = {(STATUS_W - 2)'(0), ovr_q, busy_q};

endmodule

// File: tb/tb_uart_tx_port.sv
// Self-checking bench for uart_tx_port at 4 clocks per bit against a frame-position reference model.
module tb_uart_tx_port;

  localparam int unsigned CPB   = 4;
  localparam int          FRAME = 10 * CPB;

  logic clk = 1'b0;
  logic reset;

  uart_tx_port_if bus();

  uart_tx_port #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: a frame is just a position 0..FRAME-1 plus the byte it carries.
  bit         m_active = 1'b0;
  int         m_pos    = 0;
  logic [7:0] m_byte   = 8'h00;
  bit         m_ovr    = 1'b0;

  function automatic logic exp_tx();
    int b;
    if (!m_active) return 1'b1;
    b = m_pos / int'(CPB);
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_byte[b-1];
  endfunction

  function automatic logic [7:0] exp_status();
    return {6'b000000, m_ovr, m_active};
  endfunction

  // One clock: apply inputs, advance DUT and model together, then scramble data_in.
  task automatic step(input logic r, input logic w, input logic [7:0] d, input logic c);
    reset       = r;
    bus.wr      = w;
    bus.data_in = d;
    bus.clr_ovr = c;
    @(posedge clk);
    if (r) begin
      m_active = 1'b0;
      m_pos    = 0;
      m_ovr    = 1'b0;
    end else begin
      if (w && m_active) m_ovr = 1'b1;
      else if (c)        m_ovr = 1'b0;
      if (m_active) begin
        m_pos++;
        if (m_pos == FRAME) m_active = 1'b0;
      end else if (w) begin
        m_active = 1'b1;
        m_pos    = 0;
        m_byte   = d;
      end
    end
    #1;
    reset       = 1'b0;
    bus.wr      = 1'b0;
    bus.clr_ovr = 1'b0;
    bus.data_in = 8'($urandom);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 8'h00, 1'b0);
      total++;
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.status !== 8'h00) begin
        bad++;
        $display("FAIL reset cyc=%0d tx=%b busy=%b status=%h required tx=1 busy=0 status=00",
                 i, bus.tx, bus.busy, bus.status);
      end
    end
  endtask

  task automatic test_frame_a5();
    logic [9:0] levels;
    logic [9:0] want;
    int busy_cycles;
    busy_cycles = 0;
    levels = '0;
    want   = 10'b1_10100101_0;
    for (int i = 0; i < FRAME + 4; i++) begin
      step(1'b0, (i == 0), 8'hA5, 1'b0);
      if (bus.busy === 1'b1) busy_cycles++;
      if (i < FRAME && (i % int'(CPB)) == 2) levels[i / int'(CPB)] = bus.tx;
      total++;
      if (bus.tx !== exp_tx() || bus.busy !== m_active || bus.status !== exp_status()) begin
        bad++;
        $display("FAIL frame_a5 cyc=%0d tx=%b/%b busy=%b/%b status=%h/%h", i,
                 bus.tx, exp_tx(), bus.busy, m_active, bus.status, exp_status());
      end
    end
    total++;
    if (levels !== want) begin
      bad++;
      $display("FAIL frame_a5_bits got=%b required=%b", levels, want);
    end
    total++;
    if (busy_cycles != FRAME) begin
      bad++;
      $display("FAIL frame_a5_busy_len got=%0d required=%0d", busy_cycles, FRAME);
    end
  endtask

  task automatic test_overrun();
    for (int i = 0; i < FRAME + 4; i++) begin
      step(1'b0, (i == 0) || (i == 10), (i == 0) ? 8'h3C : 8'hFF, 1'b0);
      total++;
      if (bus.tx !== exp_tx() || bus.busy !== m_active || bus.status !== exp_status()) begin
        bad++;
        $display("FAIL overrun cyc=%0d tx=%b/%b busy=%b/%b status=%h/%h", i,
                 bus.tx, exp_tx(), bus.busy, m_active, bus.status, exp_status());
      end
    end
    total++;
    if (bus.status !== 8'h02) begin
      bad++;
      $display("FAIL overrun_status_after got=%h required=02", bus.status);
    end
  endtask

  task automatic test_clr_ovr();
    step(1'b0, 1'b1, 8'h11, 1'b0);
    step(1'b0, 1'b1, 8'h22, 1'b1);
    total++;
    if (bus.status !== 8'h03) begin
      bad++;
      $display("FAIL clr_ovr_set_wins got=%h required=03", bus.status);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    total++;
    if (bus.status !== 8'h01) begin
      bad++;
      $display("FAIL clr_ovr_clear got=%h required=01", bus.status);
    end
    for (int i = 0; i < FRAME; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0);
      total++;
      if (bus.tx !== exp_tx() || bus.busy !== m_active || bus.status !== exp_status()) begin
        bad++;
        $display("FAIL clr_ovr_frame cyc=%0d tx=%b/%b busy=%b/%b status=%h/%h", i,
                 bus.tx, exp_tx(), bus.busy, m_active, bus.status, exp_status());
      end
    end
  endtask

  task automatic test_back_to_back();
    int idle_high;
    idle_high = 0;
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      step(1'b0, (i == 0) || (i == FRAME + 1), (i == 0) ? 8'h00 : 8'hFF, 1'b0);
      if (i > 0 && i <= FRAME + 1 && bus.busy === 1'b0) idle_high++;
      total++;
      if (bus.tx !== exp_tx() || bus.busy !== m_active || bus.status !== exp_status()) begin
        bad++;
        $display("FAIL back_to_back cyc=%0d tx=%b/%b busy=%b/%b status=%h/%h", i,
                 bus.tx, exp_tx(), bus.busy, m_active, bus.status, exp_status());
      end
    end
    total++;
    if (idle_high != 1 || bus.status !== 8'h00) begin
      bad++;
      $display("FAIL back_to_back_gap idle=%0d status=%h required idle=1 status=00",
               idle_high, bus.status);
    end
  endtask

  task automatic test_reset_mid_frame();
    // Offset 17 falls inside data bit 3 (offsets 16..19 at 4 clocks per bit).
    for (int i = 0; i < 18; i++) step(1'b0, (i == 0), 8'($urandom), 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    total++;
    if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.status !== 8'h00) begin
      bad++;
      $display("FAIL reset_mid_frame tx=%b busy=%b status=%h required tx=1 busy=0 status=00",
               bus.tx, bus.busy, bus.status);
    end
    for (int i = 0; i < FRAME; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0);
      total++;
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_mid_frame_quiet cyc=%0d tx=%b busy=%b required tx=1 busy=0",
                 i, bus.tx, bus.busy);
      end
    end
  endtask

  task automatic test_reset_with_wr();
    step(1'b1, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0);
      total++;
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.status !== 8'h00) begin
        bad++;
        $display("FAIL reset_with_wr cyc=%0d tx=%b busy=%b status=%h required 1/0/00",
                 i, bus.tx, bus.busy, bus.status);
      end
    end
  endtask

  task automatic test_random();
    logic r, w, c;
    for (int i = 0; i < 1500; i++) begin
      r = ($urandom_range(0, 299) == 0);
      w = ($urandom_range(0, 29) == 0);
      c = ($urandom_range(0, 39) == 0);
      step(r, w, 8'($urandom), c);
      total++;
      if (bus.tx !== exp_tx() || bus.busy !== m_active || bus.status !== exp_status()) begin
        bad++;
        $display("FAIL random cyc=%0d tx=%b/%b busy=%b/%b status=%h/%h", i,
                 bus.tx, exp_tx(), bus.busy, m_active, bus.status, exp_status());
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    bus.wr      = 1'b0;
    bus.clr_ovr = 1'b0;
    bus.data_in = 8'h00;
    test_reset();
    test_frame_a5();
    test_overrun();
    test_clr_ovr();
    test_back_to_back();
    test_reset_mid_frame();
    test_reset_with_wr();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
